tx_rx: RTL and testbench



---
 rtl/tx_rx_pkg.sv | 19 +
 rtl/tx_rx_receiver.sv | 49 ++++
 rtl/tx_rx_sender.sv | 51 +++++
 rtl/tx_rx.sv | 46 ++++
 tb/tb_tx_rx.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/tx_rx_pkg.sv
// Shared types and constants for the tx_rx loopback link.
// Holds the sender state encoding and the pattern ROM contents.
package tx_rx_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

  // Pattern word i is i*0x11; callers truncate to their data width.
  function automatic logic [31:0] rom_word(input logic [31:0] i);
    return i * 32'h11;
  endfunction

endpackage

// File: rtl/tx_rx_receiver.sv
// Accepts one word per handshake and stores it at an incrementing RAM address.
// RAM contents survive reset; only the control state is cleared.
module tx_rx_receiver
  import tx_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_ready,
  output logic              rx_finish
);

  logic [ADDR_W-1:0] addr;
  logic              inc;
  logic              last;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign inc  = tx_valid && rx_ready;
  assign last = (addr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ready  <= 1'b0;
      rx_finish <= 1'b0;
      addr      <= '0;
    end else if (inc) begin
      if (last) begin
        rx_finish <= 1'b1;
        rx_ready  <= 1'b0;
        addr      <= '0;
      end else begin
        addr <= addr + 1'b1;
      end
    end else if (!rx_finish) begin
      rx_ready <= 1'b1;
    end
  end

  // Gated by rst_n so a word on the bus during the reset edge is not stored.
  always_ff @(posedge clk) begin
    if (rst_n && inc) mem[addr] <= tx_data;
  end

endmodule

// File: rtl/tx_rx_sender.sv
// Streams DEPTH pattern words over a valid/ready handshake, then parks in DONE.
// The word index is the only datapath state; tx_data is a pure ROM lookup.
module tx_rx_sender
  import tx_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_finish
);

  tx_state_t         state;
  tx_state_t         state_nx;
  logic [ADDR_W-1:0] idx;
  logic              hs;

  assign hs      = tx_valid && rx_ready;
  assign tx_data = DATA_W'(rom_word(32'(idx)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (hs) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    tx_valid  = 1'b0;
    tx_finish = 1'b0;
    case (state)
      IDLE: state_nx = SEND;
      SEND: begin
        tx_valid = 1'b1;
        if (rx_ready && idx == ADDR_W'(DEPTH - 1)) state_nx = DONE;
      end
      DONE: tx_finish = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/tx_rx.sv
// Loopback link top: sender u_tx feeds receiver u_rx; wiring only.
module tx_rx
  import tx_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tx_finish,
  output logic rx_finish
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              rx_ready;

  tx_rx_sender #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_ready  (rx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_finish (tx_finish)
  );

  tx_rx_receiver #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .rx_ready  (rx_ready),
    .rx_finish (rx_finish)
  );

endmodule

// File: tb/tb_tx_rx.sv
// Directed bench for tx_rx: reset, full stream, post-finish hold, mid-stream reset.
module tb_tx_rx;

  logic clk_tb = 1'b0;
  logic rst_n;
  logic tx_finish;
  logic rx_finish;

  int errors = 0;
  int checks = 0;

  tx_rx #(.DATA_W(8), .DEPTH(16)) dut (
    .clk       (clk_tb),
    .rst_n     (rst_n),
    .tx_finish (tx_finish),
    .rx_finish (rx_finish)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_d;
    logic       p_hs;
    logic       p_valid;
    logic [3:0] p_addr;
    logic [7:0] p_data;
    int         pulses;
    int         hs_cnt;
    int         cyc;

    rst_n = 1'b0;
    repeat (2) @(posedge clk_tb);
    @(negedge clk_tb);  // t=20
    check("rst_tx_valid",  32'(dut.u_tx.tx_valid), 32'd0);
    check("rst_rx_ready",  32'(dut.u_rx.rx_ready), 32'd0);
    check("rst_inc",       32'(dut.u_rx.inc), 32'd0);
    check("rst_addr",      32'(dut.u_rx.addr), 32'd0);
    check("rst_tx_finish", 32'(tx_finish), 32'd0);
    check("rst_rx_finish", 32'(rx_finish), 32'd0);

    @(negedge clk_tb);  // t=30
    rst_n = 1'b1;
    @(negedge clk_tb);  // t=40, after first non-reset edge at 35
    check("first_tx_valid", 32'(dut.u_tx.tx_valid), 32'd1);
    check("first_rx_ready", 32'(dut.u_rx.rx_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      exp_d = 8'(i * 17);
      check($sformatf("stream_inc_%0d", i),  32'(dut.u_rx.inc), 32'd1);
      check($sformatf("stream_addr_%0d", i), 32'(dut.u_rx.addr), 32'(i));
      check($sformatf("stream_data_%0d", i), 32'(dut.u_tx.tx_data), 32'(exp_d));
      check($sformatf("stream_txfin_%0d", i), 32'(tx_finish), 32'd0);
      check($sformatf("stream_rxfin_%0d", i), 32'(rx_finish), 32'd0);
      @(negedge clk_tb);
    end
    // t=200: last handshake happened at edge 195
    check("done_rx_finish", 32'(rx_finish), 32'd1);
    check("done_tx_finish", 32'(tx_finish), 32'd1);
    check("done_tx_valid",  32'(dut.u_tx.tx_valid), 32'd0);
    check("done_rx_ready",  32'(dut.u_rx.rx_ready), 32'd0);
    check("done_addr",      32'(dut.u_rx.addr), 32'd0);

    for (int i = 0; i < 16; i++) begin
      exp_d = 8'(i * 17);
      check($sformatf("mem_%0d", i), 32'(dut.u_rx.mem[i]), 32'(exp_d));
    end

    pulses = 0;
    repeat (20) begin
      @(negedge clk_tb);
      if (dut.u_rx.inc || dut.u_tx.tx_valid) pulses++;
    end
    check("post_no_inc",    32'(pulses), 32'd0);
    check("post_rx_finish", 32'(rx_finish), 32'd1);
    check("post_tx_finish", 32'(tx_finish), 32'd1);
    check("post_addr",      32'(dut.u_rx.addr), 32'd0);

    // Reset, restart, then interrupt the stream once addr reaches 5
    rst_n = 1'b0;
    @(negedge clk_tb);
    check("rst2_rx_finish", 32'(rx_finish), 32'd0);
    check("rst2_tx_finish", 32'(tx_finish), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_tb);
    check("rst2_tx_data", 32'(dut.u_tx.tx_data), 32'h00);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("part_addr_%0d", i), 32'(dut.u_rx.addr), 32'(i));
      check($sformatf("part_inc_%0d", i),  32'(dut.u_rx.inc), 32'd1);
      if (i < 5) @(negedge clk_tb);
    end
    rst_n = 1'b0;
    @(negedge clk_tb);
    check("mid_addr",      32'(dut.u_rx.addr), 32'd0);
    check("mid_rx_finish", 32'(rx_finish), 32'd0);
    check("mid_tx_finish", 32'(tx_finish), 32'd0);
    check("mid_rx_ready",  32'(dut.u_rx.rx_ready), 32'd0);
    check("mid_tx_valid",  32'(dut.u_tx.tx_valid), 32'd0);
    check("mid_mem5_kept", 32'(dut.u_rx.mem[5]), 32'h55);

    rst_n = 1'b1;
    @(negedge clk_tb);
    check("restart_tx_valid", 32'(dut.u_tx.tx_valid), 32'd1);
    check("restart_tx_data",  32'(dut.u_tx.tx_data), 32'h00);
    check("restart_addr",     32'(dut.u_rx.addr), 32'd0);

    p_hs    = dut.u_tx.tx_valid && dut.u_rx.rx_ready;
    p_valid = dut.u_tx.tx_valid;
    p_addr  = dut.u_rx.addr;
    p_data  = dut.u_tx.tx_data;
    hs_cnt  = 0;
    cyc     = 0;
    while (!rx_finish && cyc < 40) begin
      @(negedge clk_tb);
      cyc++;
      if (p_hs) begin
        hs_cnt++;
        check("inv_addr_inc", 32'(dut.u_rx.addr), 32'(4'(p_addr + 4'd1)));
      end else begin
        check("inv_addr_hold", 32'(dut.u_rx.addr), 32'(p_addr));
      end
      if (p_valid && !p_hs && dut.u_tx.tx_valid)
        check("inv_data_hold", 32'(dut.u_tx.tx_data), 32'(p_data));
      p_hs    = dut.u_tx.tx_valid && dut.u_rx.rx_ready;
      p_valid = dut.u_tx.tx_valid;
      p_addr  = dut.u_rx.addr;
      p_data  = dut.u_tx.tx_data;
    end
    check("restart_rx_finish", 32'(rx_finish), 32'd1);
    check("restart_tx_finish", 32'(tx_finish), 32'd1);
    check("restart_hs_count",  32'(hs_cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_d = 8'(i * 17);
      check($sformatf("mem2_%0d", i), 32'(dut.u_rx.mem[i]), 32'(exp_d));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
